// File: rtl/fp_wb_collector_pkg.sv
// Shared types for the FP writeback collector and its round-robin arbiter.
package fp_wb_collector_pkg;

    localparam int FLOPOCO_W = 34;
    localparam int ID_BITS = 4;
    localparam int FP_WB_UNIT_W = 2;

    typedef logic [FLOPOCO_W-1:0] flopoco_t;
    typedef logic [ID_BITS-1:0] id_t;

    typedef struct packed {
        flopoco_t data;
        id_t id;
        logic [FP_WB_UNIT_W-1:0] unit;
    } fp_wb_entry_t;

    // One-step modular wrap; callers never exceed 2*n-1.
    function automatic int rr_wrap(input int idx, input int n);
        return (idx >= n) ? idx - n : idx;
    endfunction

endpackage

// File: rtl/fp_wb_rr_arbiter.sv
// Round-robin arbiter: search begins one past the last granted index.
module fp_wb_rr_arbiter
    import fp_wb_collector_pkg::*;
#(
    parameter int N = 3,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     requests,
    input  logic             enable,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic [IDX_W-1:0] last_grant
);

    logic [IDX_W-1:0] last_grant_q;
    logic [IDX_W-1:0] last_grant_d;
    logic             found;
    int               cand;

    always_comb begin
        grant = '0;
        grant_idx = '0;
        found = 1'b0;
        cand = 0;
        for (int off = 1; off <= N; off++) begin
            cand = rr_wrap(int'(last_grant_q) + off, N);
            if (!found && enable && requests[cand]) begin
                found = 1'b1;
                grant_idx = IDX_W'(cand);
                grant[cand] = 1'b1;
            end
        end
    end

    assign last_grant_d = found ? grant_idx : last_grant_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= IDX_W'(N - 1);
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

    assign last_grant = last_grant_q;

endmodule

// File: rtl/fp_wb_collector.sv
// FP writeback collector: arbitrates unit results into a small FIFO
// drained toward the FP register-file write port.
module fp_wb_collector
    import fp_wb_collector_pkg::*;
#(
    parameter int NUM_UNITS = 3,
    parameter int DATA_W = 34,
    parameter int ID_W = $bits(id_t),
    parameter int DEPTH = 2,
    localparam int UNIT_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_UNITS-1:0]             unit_done,
    input  logic [NUM_UNITS-1:0][DATA_W-1:0] unit_rd,
    input  logic [NUM_UNITS-1:0][ID_W-1:0]   unit_id,
    output logic [NUM_UNITS-1:0]             unit_ack,
    output logic                             out_valid,
    output logic [DATA_W-1:0]                out_data,
    output logic [ID_W-1:0]                  out_id,
    output logic [UNIT_W-1:0]                out_unit,
    input  logic                             out_ready
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [ID_W-1:0]   id;
        logic [UNIT_W-1:0] unit;
    } entry_t;

    entry_t           mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic              full;
    logic              pop;
    logic              push;
    logic              space;
    logic              arb_en;
    logic [UNIT_W-1:0] grant_idx;
    logic [UNIT_W-1:0] last_grant;
    entry_t            push_entry;
    entry_t            head;

    assign full = (count_q == CNT_W'(DEPTH));
    assign out_valid = (count_q != '0);
    assign pop = out_valid && out_ready;
    assign space = !full || pop;
    // Reset gates the grant so no unit advances on a flushed cycle.
    assign arb_en = space && !rst;

    fp_wb_rr_arbiter #(
        .N(NUM_UNITS)
    ) u_arb (
        .clk(clk),
        .rst(rst),
        .requests(unit_done),
        .enable(arb_en),
        .grant(unit_ack),
        .grant_idx(grant_idx),
        .last_grant(last_grant)
    );

    assign push = |unit_ack;

    always_comb begin
        push_entry = '0;
        push_entry.data = unit_rd[grant_idx];
        push_entry.id = unit_id[grant_idx];
        push_entry.unit = grant_idx;
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d = count_q;
        case ({push, pop})
            2'b10: count_d = count_q + CNT_W'(1);
            2'b01: count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset; the count alone qualifies the head.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_entry;
        end
    end

    assign head = mem_q[rd_ptr_q];
    assign out_data = head.data;
    assign out_id = head.id;
    assign out_unit = head.unit;

endmodule

// File: tb/tb_fp_wb_collector.sv
// Directed and scoreboarded checks for fp_wb_collector (3 units, depth 2).
module tb_fp_wb_collector;

    logic             clk;
    logic             rst;
    logic [2:0]       unit_done;
    logic [2:0][33:0] unit_rd;
    logic [2:0][3:0]  unit_id;
    logic [2:0]       unit_ack;
    logic             out_valid;
    logic [33:0]      out_data;
    logic [3:0]       out_id;
    logic [1:0]       out_unit;
    logic             out_ready;

    int total = 0;
    int bad = 0;

    typedef struct packed {
        logic [33:0] d;
        logic [3:0]  i;
        logic [1:0]  u;
    } sb_t;

    sb_t         q[$];
    sb_t         hd;
    logic [2:0]  pend;
    logic [33:0] pdata [3];
    logic [3:0]  pid [3];
    int          mlast;
    int          eg;
    int          mcnt;
    int          idx;
    logic        space;
    logic [2:0]  exp_ack;

    fp_wb_collector dut (
        .clk(clk),
        .rst(rst),
        .unit_done(unit_done),
        .unit_rd(unit_rd),
        .unit_id(unit_id),
        .unit_ack(unit_ack),
        .out_valid(out_valid),
        .out_data(out_data),
        .out_id(out_id),
        .out_unit(out_unit),
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        clk = 1'b0;
        rst = 1'b1;
        unit_done = '0;
        unit_rd = '0;
        unit_id = '0;
        out_ready = 1'b0;
        tick();

        // reset state, ack suppressed during reset
        unit_done = 3'b111;
        #1;
        chk("rst_ack", 64'(unit_ack), 64'(3'b000));
        chk("rst_valid", 64'(out_valid), 64'(1'b0));
        tick();
        rst = 1'b0;
        unit_done = '0;
        #1;
        chk("reset_empty", 64'(out_valid), 64'(1'b0));
        chk("idle_ack", 64'(unit_ack), 64'(3'b000));

        // single result
        unit_rd[1] = 34'h0_3F80_0000;
        unit_id[1] = 4'd5;
        unit_done = 3'b010;
        #1;
        chk("single_ack", 64'(unit_ack), 64'(3'b010));
        chk("single_nobypass", 64'(out_valid), 64'(1'b0));
        tick();
        unit_done = '0;
        #1;
        chk("single_valid", 64'(out_valid), 64'(1'b1));
        chk("single_data", 64'(out_data), 64'(34'h0_3F80_0000));
        chk("single_id", 64'(out_id), 64'(4'd5));
        chk("single_unit", 64'(out_unit), 64'(2'd1));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        #1;
        chk("single_drained", 64'(out_valid), 64'(1'b0));

        // round-robin with all units done
        pulse_reset();
        unit_rd[0] = 34'h1_1111_1111;
        unit_rd[1] = 34'h2_2222_2222;
        unit_rd[2] = 34'h3_3333_3333;
        unit_id[0] = 4'd1;
        unit_id[1] = 4'd2;
        unit_id[2] = 4'd3;
        unit_done = 3'b111;
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            #1;
            chk("rr_ack", 64'(unit_ack), 64'(3'b001 << (k % 3)));
            if (k == 0) begin
                chk("rr_first_empty", 64'(out_valid), 64'(1'b0));
            end else begin
                chk("rr_valid", 64'(out_valid), 64'(1'b1));
                chk("rr_unit", 64'(out_unit), 64'((k - 1) % 3));
                chk("rr_data", 64'(out_data), 64'(unit_rd[(k - 1) % 3]));
            end
            tick();
        end
        unit_done = '0;
        #1;
        chk("rr_last_unit", 64'(out_unit), 64'(2'd2));
        tick();
        chk("rr_drained", 64'(out_valid), 64'(1'b0));

        // backpressure: fill, stall, then pop and push together
        pulse_reset();
        out_ready = 1'b0;
        unit_rd[0] = 34'h0_4000_0000;
        unit_id[0] = 4'd7;
        unit_rd[2] = 34'h1_C0A0_0000;
        unit_id[2] = 4'd9;
        unit_done = 3'b101;
        #1;
        chk("bp_ack0", 64'(unit_ack), 64'(3'b001));
        tick();
        unit_done = 3'b100;
        #1;
        chk("bp_ack2", 64'(unit_ack), 64'(3'b100));
        chk("bp_head_unit", 64'(out_unit), 64'(2'd0));
        tick();
        unit_done = 3'b101;
        unit_rd[0] = 34'h2_BF80_0000;
        unit_id[0] = 4'd4;
        #1;
        chk("bp_full_noack", 64'(unit_ack), 64'(3'b000));
        chk("bp_hold_data", 64'(out_data), 64'(34'h0_4000_0000));
        tick();
        chk("bp_full_noack2", 64'(unit_ack), 64'(3'b000));
        chk("bp_hold_data2", 64'(out_data), 64'(34'h0_4000_0000));
        chk("bp_hold_id2", 64'(out_id), 64'(4'd7));
        chk("bp_hold_unit2", 64'(out_unit), 64'(2'd0));
        out_ready = 1'b1;
        #1;
        chk("bp_full_pushpop_ack", 64'(unit_ack), 64'(3'b001));
        tick();
        out_ready = 1'b0;
        unit_done = 3'b100;
        #1;
        chk("bp_head_next", 64'(out_unit), 64'(2'd2));
        chk("bp_head_next_data", 64'(out_data), 64'(34'h1_C0A0_0000));
        chk("bp_still_full", 64'(unit_ack), 64'(3'b000));

        // full simultaneous push and pop with unit 1
        unit_rd[1] = 34'h3_0000_0001;
        unit_id[1] = 4'd2;
        unit_done = 3'b010;
        out_ready = 1'b1;
        #1;
        chk("fs_ack1", 64'(unit_ack), 64'(3'b010));
        tick();
        unit_done = '0;
        out_ready = 1'b0;
        #1;
        chk("fs_head_unit", 64'(out_unit), 64'(2'd0));
        chk("fs_head_data", 64'(out_data), 64'(34'h2_BF80_0000));
        out_ready = 1'b1;
        tick();
        chk("fs_tail_unit", 64'(out_unit), 64'(2'd1));
        chk("fs_tail_data", 64'(out_data), 64'(34'h3_0000_0001));
        tick();
        out_ready = 1'b0;
        #1;
        chk("fs_drained", 64'(out_valid), 64'(1'b0));

        // scoreboarded random traffic
        unit_done = '0;
        pulse_reset();
        pend = '0;
        mlast = 2;
        for (int c = 0; c < 1000; c++) begin
            for (int u = 0; u < 3; u++) begin
                if (!pend[u] && $urandom_range(1, 0) == 1) begin
                    pend[u] = 1'b1;
                    pdata[u] = {2'($urandom_range(3, 0)), $urandom()};
                    pid[u] = 4'($urandom_range(15, 0));
                end
                unit_rd[u] = pdata[u];
                unit_id[u] = pid[u];
            end
            unit_done = pend;
            out_ready = 1'($urandom_range(1, 0));
            #1;
            mcnt = q.size();
            space = (mcnt < 2) || (mcnt > 0 && out_ready);
            eg = -1;
            if (space) begin
                for (int off = 1; off <= 3; off++) begin
                    idx = (mlast + off) % 3;
                    if (eg < 0 && pend[idx]) eg = idx;
                end
            end
            exp_ack = (eg < 0) ? 3'b000 : 3'(1 << eg);
            chk("sb_ack", 64'(unit_ack), 64'(exp_ack));
            chk("sb_valid", 64'(out_valid), 64'(mcnt != 0));
            if (mcnt != 0) begin
                hd = q[0];
                chk("sb_data", 64'(out_data), 64'(hd.d));
                chk("sb_id", 64'(out_id), 64'(hd.i));
                chk("sb_unit", 64'(out_unit), 64'(hd.u));
                if (out_ready) void'(q.pop_front());
            end
            if (eg >= 0) begin
                q.push_back({pdata[eg], pid[eg], 2'(eg)});
                pend[eg] = 1'b0;
                mlast = eg;
            end
            tick();
        end

        // reset mid-operation
        out_ready = 1'b0;
        unit_done = '0;
        pulse_reset();
        unit_done = 3'b001;
        tick();
        unit_done = 3'b010;
        tick();
        unit_done = '0;
        #1;
        chk("mid_queued", 64'(out_valid), 64'(1'b1));
        rst = 1'b1;
        unit_done = 3'b111;
        #1;
        chk("mid_rst_ack", 64'(unit_ack), 64'(3'b000));
        tick();
        chk("mid_rst_valid", 64'(out_valid), 64'(1'b0));
        chk("mid_rst_ack2", 64'(unit_ack), 64'(3'b000));
        rst = 1'b0;
        #1;
        chk("mid_post_ack", 64'(unit_ack), 64'(3'b001));
        chk("mid_post_empty", 64'(out_valid), 64'(1'b0));
        tick();
        unit_done = '0;
        #1;
        chk("mid_post_valid", 64'(out_valid), 64'(1'b1));
        chk("mid_post_unit", 64'(out_unit), 64'(2'd0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
